// File: rtl/gameshow_round_ctrl.sv
// gameshow_round_ctrl: buzzer round arbiter with round-robin tie break,
// per-player lockout and a per-answer countdown.
// Optional feature macro: GAMESHOW_FALSE_START_EN (buzzes while idle lock
// the player out of the next round).
module gameshow_round_ctrl #(
  parameter int N_PLAYERS     = 6,
  parameter int ANSWER_CYCLES = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 arm,
  input  logic [N_PLAYERS-1:0] buzz,
  input  logic                 judge_ok,
  input  logic                 judge_bad,
  output logic [N_PLAYERS-1:0] winner,
  output logic [N_PLAYERS-1:0] lockout,
  output logic [1:0]           state,
  output logic                 timeout,
  output logic                 round_over
);

  localparam int PW = (N_PLAYERS > 1) ? $clog2(N_PLAYERS) : 1;
  localparam int TW = (ANSWER_CYCLES > 1) ? $clog2(ANSWER_CYCLES) : 1;
  localparam logic [TW-1:0] TIMER_LOAD = TW'(ANSWER_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_OPEN   = 2'd1,
    S_ANSWER = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t               state_q;
  logic [N_PLAYERS-1:0] winner_q;
  logic [N_PLAYERS-1:0] lockout_q;
  logic                 timeout_q;
  logic [PW-1:0]        ptr_q;
  logic [TW-1:0]        timer_q;

`ifdef GAMESHOW_FALSE_START_EN
  logic [N_PLAYERS-1:0] false_start_q;
`endif

  // Arbitration helpers
  logic [N_PLAYERS-1:0] eligible;
  logic                 grant_found;
  logic [N_PLAYERS-1:0] grant_onehot;
  logic [PW-1:0]        ptr_d;
  logic [N_PLAYERS-1:0] lockout_d;
  logic                 all_locked;
  int                   cand;
  int                   grant_idx;

  assign eligible = buzz & ~lockout_q;

  // Round-robin search: first eligible player at or above ptr, wrapping
  always_comb begin
    grant_found  = 1'b0;
    grant_onehot = '0;
    grant_idx    = 0;
    cand         = 0;
    for (int k = 0; k < N_PLAYERS; k++) begin
      cand = int'(ptr_q) + k;
      if (cand >= N_PLAYERS) begin
        cand = cand - N_PLAYERS;
      end
      if (!grant_found && eligible[cand]) begin
        grant_found        = 1'b1;
        grant_idx          = cand;
        grant_onehot[cand] = 1'b1;
      end
    end
  end

  // Pointer moves just past the granted player so ties rotate fairly
  always_comb begin
    if (grant_idx >= N_PLAYERS - 1) begin
      ptr_d = '0;
    end else begin
      ptr_d = PW'(grant_idx + 1);
    end
  end

  // Lockout after the current answerer fails, and whether anyone is left
  assign lockout_d  = lockout_q | winner_q;
  assign all_locked = &lockout_d;

  // Round FSM with registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      winner_q  <= '0;
      lockout_q <= '0;
      timeout_q <= 1'b0;
      ptr_q     <= '0;
      timer_q   <= '0;
`ifdef GAMESHOW_FALSE_START_EN
      false_start_q <= '0;
`endif
    end else begin
      timeout_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (arm) begin
            winner_q <= '0;
`ifdef GAMESHOW_FALSE_START_EN
            // Early buzzers start the round already locked out
            lockout_q     <= false_start_q;
            false_start_q <= '0;
            state_q       <= (&false_start_q) ? S_DONE : S_OPEN;
`else
            lockout_q <= '0;
            state_q   <= S_OPEN;
`endif
          end
`ifdef GAMESHOW_FALSE_START_EN
          else begin
            false_start_q <= false_start_q | buzz;
          end
`endif
        end

        S_OPEN: begin
          if (grant_found) begin
            winner_q <= grant_onehot;
            timer_q  <= TIMER_LOAD;
            ptr_q    <= ptr_d;
            state_q  <= S_ANSWER;
          end
        end

        S_ANSWER: begin
          if (judge_ok) begin
            // Correct answer: winner stays on display through DONE
            state_q <= S_DONE;
          end else if (judge_bad || (timer_q == '0)) begin
            // Wrong answer or expiry; a judge input suppresses the timeout
            lockout_q <= lockout_d;
            winner_q  <= '0;
            timeout_q <= ~judge_bad;
            state_q   <= all_locked ? S_DONE : S_OPEN;
          end else begin
            timer_q <= timer_q - 1'b1;
          end
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign winner     = winner_q;
  assign lockout    = lockout_q;
  assign state      = state_q;
  assign timeout    = timeout_q;
  assign round_over = (state_q == S_DONE);

endmodule

// File: tb/tb_gameshow_round_ctrl.sv
// Scoreboard bench for gameshow_round_ctrl (N_PLAYERS=6, ANSWER_CYCLES=8):
// directed round scenarios followed by randomized play, all checked against
// a round-level reference model.
module tb_gameshow_round_ctrl;

  localparam int N   = 6;
  localparam int ANS = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         arm = 1'b0;
  logic [N-1:0] buzz = '0;
  logic         judge_ok = 1'b0;
  logic         judge_bad = 1'b0;
  logic [N-1:0] winner;
  logic [N-1:0] lockout;
  logic [1:0]   state;
  logic         timeout;
  logic         round_over;

  gameshow_round_ctrl #(.N_PLAYERS(N), .ANSWER_CYCLES(ANS)) dut (
    .clk        (clk),
    .rst        (rst),
    .arm        (arm),
    .buzz       (buzz),
    .judge_ok   (judge_ok),
    .judge_bad  (judge_bad),
    .winner     (winner),
    .lockout    (lockout),
    .state      (state),
    .timeout    (timeout),
    .round_over (round_over)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]   st;
    logic [N-1:0] win;
    logic [N-1:0] lock;
    logic         to;
    logic         ro;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  bit   mon_en   = 1'b0;

  // Reference model: phase 0 idle, 1 open, 2 answering, 3 done
  int           m_phase;
  logic [N-1:0] m_win;
  logic [N-1:0] m_lock;
  logic [N-1:0] m_fs;
  int           m_next;   // player the search starts from
  int           m_left;   // answer cycles remaining including this one
  logic         m_to;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic model(input logic a, input logic [N-1:0] b, input logic ok,
                       input logic bad, input logic r);
    int found;
    m_to = 1'b0;
    if (r) begin
      m_phase = 0; m_win = '0; m_lock = '0; m_fs = '0; m_next = 0; m_left = 0;
    end else if (m_phase == 0 || m_phase == 3) begin
      if (a) begin
        m_win = '0;
`ifdef GAMESHOW_FALSE_START_EN
        m_lock  = m_fs;
        m_fs    = '0;
        m_phase = (m_lock == {N{1'b1}}) ? 3 : 1;
`else
        m_lock  = '0;
        m_phase = 1;
`endif
      end else begin
        m_fs = m_fs | b;
      end
    end else if (m_phase == 1) begin
      found = -1;
      for (int k = 0; k < N; k++) begin
        int p;
        p = (m_next + k) % N;
        if (found < 0 && b[p] && !m_lock[p]) found = p;
      end
      if (found >= 0) begin
        m_win = '0;
        m_win[found] = 1'b1;
        m_left  = ANS;
        m_next  = (found + 1) % N;
        m_phase = 2;
      end
    end else begin
      if (ok) begin
        m_phase = 3;
      end else if (bad || m_left == 1) begin
        m_to    = !bad;
        m_lock  = m_lock | m_win;
        m_win   = '0;
        m_phase = (m_lock == {N{1'b1}}) ? 3 : 1;
      end else begin
        m_left--;
      end
    end
  endtask

  // Drive one cycle of inputs, record the expected post-edge outputs
  task automatic step(input logic a, input logic [N-1:0] b, input logic ok,
                      input logic bad, input logic r);
    exp_t e;
    @(negedge clk);
    arm = a; buzz = b; judge_ok = ok; judge_bad = bad; rst = r;
    model(a, b, ok, bad, r);
    e.st = m_phase[1:0]; e.win = m_win; e.lock = m_lock; e.to = m_to;
    e.ro = (m_phase == 3);
    exp_q.push_back(e);
    mon_en = 1'b1;
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: every cycle the DUT presents outputs, compare with the scoreboard
  always @(posedge clk) begin
    #1;
    if (mon_en) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL scoreboard_empty at %0t", $time);
      end else begin
        exp_t e;
        exp_t a;
        e = exp_q.pop_front();
        a.st = state; a.win = winner; a.lock = lockout; a.to = timeout; a.ro = round_over;
        chk("scoreboard{state,winner,lockout,timeout,round_over}", 32'(a), 32'(e));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    chk("reset_state", state, 0);
    chk("reset_winner", winner, 0);
    chk("reset_lockout", lockout, 0);
    chk("reset_timeout", timeout, 0);
    step(1'b0, '0, 1'b0, 1'b0, 1'b0);

    // Basic round
    step(1'b1, '0, 1'b0, 1'b0, 1'b0);
    chk("basic_open", state, 1);
    step(1'b0, 6'b000100, 1'b0, 1'b0, 1'b0);
    chk("basic_winner", winner, 6'b000100);
    chk("basic_answer", state, 2);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    chk("basic_done", state, 3);
    chk("basic_round_over", round_over, 1);
    chk("basic_winner_held", winner, 6'b000100);
    idle(2);
    chk("done_winner_hold", winner, 6'b000100);

    // Round-robin tie
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    step(1'b1, '0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 6'b100001, 1'b0, 1'b0, 1'b0);
    chk("rr_first", winner, 6'b000001);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    step(1'b1, '0, 1'b0, 1'b0, 1'b0);
    chk("rr_rearm_winner_clear", winner, 0);
    step(1'b0, 6'b100001, 1'b0, 1'b0, 1'b0);
    chk("rr_second", winner, 6'b100000);
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);

    // Timeout after exactly ANS cycles in ANSWER
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    step(1'b1, '0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 6'b000100, 1'b0, 1'b0, 1'b0);
    idle(ANS - 1);
    chk("timeout_not_early", timeout, 0);
    chk("timeout_still_answer", state, 2);
    idle(1);
    chk("timeout_pulse", timeout, 1);
    chk("timeout_lockout", lockout, 6'b000100);
    chk("timeout_winner", winner, 0);
    chk("timeout_state", state, 1);
    step(1'b0, 6'b000100, 1'b0, 1'b0, 1'b0);
    chk("timeout_one_cycle", timeout, 0);
    step(1'b0, 6'b000100, 1'b0, 1'b0, 1'b0);
    chk("locked_no_grant", state, 1);
    chk("locked_no_winner", winner, 0);

    // Exhaustion: all six granted in turn and judged bad
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    step(1'b1, '0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < N; i++) begin
      logic [N-1:0] oh;
      oh = '0;
      oh[i] = 1'b1;
      step(1'b0, {N{1'b1}}, 1'b0, 1'b0, 1'b0);
      chk($sformatf("exhaust_grant%0d", i), winner, oh);
      step(1'b0, {N{1'b1}}, 1'b0, 1'b1, 1'b0);
    end
    chk("exhaust_lockout", lockout, 6'b111111);
    chk("exhaust_done", state, 3);
    chk("exhaust_no_timeout", timeout, 0);

    // judge_ok and judge_bad together: ok wins
    step(1'b1, '0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 6'b001000, 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b1, 1'b0);
    chk("both_judge_done", state, 3);
    chk("both_judge_lockout", lockout, 0);
    chk("both_judge_winner", winner, 6'b001000);

    // Judge on the expiry cycle suppresses timeout
    step(1'b1, '0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 6'b000010, 1'b0, 1'b0, 1'b0);
    idle(ANS - 1);
    step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    chk("judge_beats_timeout", timeout, 0);
    chk("judge_beats_timeout_lock", lockout, 6'b000010);

    // Reset mid-ANSWER with timer at 5
    step(1'b0, 6'b000001, 1'b0, 1'b0, 1'b0);
    idle(2);
    chk("midrst_answer", state, 2);
    step(1'b1, '0, 1'b0, 1'b0, 1'b1);
    chk("midrst_state", state, 0);
    chk("midrst_winner", winner, 0);
    chk("midrst_lockout", lockout, 0);
    chk("midrst_timeout", timeout, 0);

    // False start
    step(1'b0, 6'b010000, 1'b0, 1'b0, 1'b0);
    step(1'b1, '0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 6'b010000, 1'b0, 1'b0, 1'b0);
`ifdef GAMESHOW_FALSE_START_EN
    chk("fs_lockout", lockout, 6'b010000);
    chk("fs_no_grant", winner, 0);
`else
    chk("fs_lockout", lockout, 0);
    chk("fs_grant", winner, 6'b010000);
`endif
    step(1'b0, '0, 1'b1, 1'b0, 1'b0);

    // Randomized play
    for (int i = 0; i < 600; i++) begin
      logic a, ok, bad, r;
      logic [N-1:0] b;
      r   = ($urandom_range(0, 99) < 2);
      a   = ($urandom_range(0, 5) == 0);
      b   = ($urandom_range(0, 2) == 0) ? N'($urandom) : '0;
      ok  = ($urandom_range(0, 13) == 0);
      bad = ($urandom_range(0, 9) == 0);
      step(a, b, ok, bad, r);
    end

    @(negedge clk);
    mon_en = 1'b0;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gameshow_round_ctrl.md
# gameshow_round_ctrl

Round controller for the gameshow buzzer system. The host opens a round, and the block arbitrates buzz-ins among players: round-robin on ties, with per-player lockout after a wrong answer or timeout. It runs a per-answer countdown and closes the round on a correct answer or when every player is locked out. It sits between the synchronized buzzer inputs and the display and host-panel outputs.

## Interface
- `N_PLAYERS`, default 6: number of buzzer inputs (2..8).
- `ANSWER_CYCLES`, default 16: answer window in clk cycles (≥2). Timer width is `$clog2(ANSWER_CYCLES)`.

- `clk` in 1: single clock; all logic on posedge.
- `rst` in 1: synchronous, active-high reset.
- `arm` in 1: host opens a round; honoured in IDLE and DONE only.
- `buzz` in N_PLAYERS: level buzzer inputs, already synchronous to clk.
- `judge_ok` in 1: host marks the current answer correct.
- `judge_bad` in 1: host marks the current answer wrong.
- `winner` out N_PLAYERS: one-hot, the player currently answering (or the round winner).
- `lockout` out N_PLAYERS: players barred for the rest of this round.
- `state` out 2: IDLE=0, OPEN=1, ANSWER=2, DONE=3.
- `timeout` out 1: one-cycle pulse when the answer window expires.
- `round_over` out 1: high while in DONE.

## Operation
- Reset values: state=IDLE; winner, lockout, timeout, round-robin pointer `ptr`, and timer all 0.
- **IDLE / DONE:**
  - On `arm`: go to OPEN, set winner=0, clear lockout (see Configuration).
  - Other inputs are ignored.
  - In DONE, winner holds its last value until `arm`.
- **OPEN:**
  - eligible = buzz & ~lockout.
  - If eligible≠0, grant the first set bit searching upward from `ptr` with wrap.
  - On grant: winner=onehot(i), timer=ANSWER_CYCLES-1, ptr=(i+1) mod N_PLAYERS, go to ANSWER.
  - judge_* inputs are ignored.
- **ANSWER:**
  - The timer decrements every cycle.
  - judge_ok → DONE; winner is held.
  - judge_bad, or timer==0 with no judge input → lockout |= winner, winner=0.
    - On the expiry path, timeout pulses.
    - If the new lockout is all-ones → DONE, else → OPEN.
  - Buzz inputs are ignored.
- **Simultaneous events:**
  - judge_ok and judge_bad together: judge_ok wins.
  - A judge input in the same cycle as timer==0: the judge wins and timeout stays 0.
  - arm outside IDLE/DONE: ignored.
- Held buttons: a locked-out player holding buzz is never granted. A still-held button from an unlocked player is granted again on re-entry to OPEN. This is intentional, because buzz is level-sensitive.
- `rst` is honoured in any state, including mid-ANSWER; all registers return to their reset values.

## Timing
- Buzz sampled in OPEN at edge k → winner and state=ANSWER visible after edge k (one-cycle latency).
- Answer window: exactly ANSWER_CYCLES cycles in ANSWER. Expiry is evaluated on the cycle where timer==0. The state leaves ANSWER at the following edge, with timeout high for that one cycle.
- Judge input at edge k → state change visible after edge k.
- `timeout` is registered, 1 cycle wide, and asserts together with the lockout update.
- `round_over` is decoded from the state register (state==DONE); it is glitch-free.

## Configuration
- `GAMESHOW_FALSE_START_EN` defined:
  - While in IDLE or DONE, buzz bits OR into a `false_start` register.
  - On `arm`, lockout is loaded from `false_start` and `false_start` is cleared.
  - If `false_start` is all-ones, `arm` goes directly to DONE.
  - `false_start` resets to 0.
- Undefined: no `false_start` register; `arm` clears lockout to 0 and buzzes outside OPEN have no effect.

## Test plan
- **Basic round** (N=6, ANSWER_CYCLES=8): reset, arm, buzz=6'b000100 → next cycle winner=000100, state=2. Then judge_ok → state=3, round_over=1, winner=000100.
- **Round-robin tie:** reset, arm, buzz=6'b100001 → winner=000001, judge_ok. Then arm, same buzz → winner=100000 (ptr=1).
- **Timeout:** winner=000100, no judge for 8 cycles → timeout high 1 cycle, lockout=000100, winner=0, state=1. Holding buzz=000100 then gives no grant.
- **Exhaustion:** all six players granted in turn, each judged bad → after the sixth, lockout=111111, state=3. judge_ok+judge_bad in the same cycle → DONE with lockout unchanged.
- **Reset mid-ANSWER:** rst while state=2 with timer=5 → next cycle state=0, winner=0, lockout=0, timeout=0.
- **False start** (macro defined): in IDLE buzz=010000, then arm → lockout=010000, and buzz=010000 in OPEN gives no grant. Without the macro: lockout=0 and winner=010000.
